// File: rtl/bit_timer_pkg.sv
// Shared types and constants for the bit timer controller.
// Holds the FSM state encoding and the smallest usable bit period.
package bit_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HALF = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_t;

    // Below two clocks the half-period would round down to zero.
    localparam int MIN_CLKS_PER_BIT = 2;

endpackage

// File: rtl/flex_counter.sv
// Programmable period counter with synchronous restart.
// A restart counts as the first cycle of the new period.
module flex_counter #(
    parameter int NUM_CNT_BITS = 8
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic                    rollover_flag
);

    localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] r_count;
    logic [NUM_CNT_BITS-1:0] w_next_count;
    logic                    r_flag;

    assign w_next_count  = (r_count == rollover_val) ? ONE : r_count + ONE;
    assign rollover_flag = r_flag;

    // The flag is registered alongside the count so it lines up with the count it reports.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
            r_flag  <= 1'b0;
        end else if (clear) begin
            r_count <= ONE;
            r_flag  <= (rollover_val == ONE);
        end else if (count_enable) begin
            r_count <= w_next_count;
            r_flag  <= (w_next_count == rollover_val);
        end else begin
            r_flag  <= 1'b0;
        end
    end

endmodule

// File: rtl/bit_timer_ctrl.sv
// Frame bit timer: issues a bit-centre strobe half a period after start,
// then one every bit period, for a programmed number of sample points.
//
// state | meaning
// IDLE  | waiting for start
// HALF  | timing the initial half bit period
// RUN   | timing full bit periods up to the last sample point
// DONE  | one-cycle frame completion, start accepted here as in IDLE
module bit_timer_ctrl
    import bit_timer_pkg::*;
#(
    parameter int NUM_CNT_BITS = 8,
    parameter int NUM_BIT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [NUM_CNT_BITS-1:0] clks_per_bit,
    input  logic [NUM_BIT_BITS-1:0] bits_per_frame,
    output logic                    busy,
    output logic                    sample_strobe,
    output logic [NUM_BIT_BITS-1:0] bit_count,
    output logic                    frame_done,
    output logic                    err
);

    localparam logic [NUM_CNT_BITS-1:0] MIN_C   = NUM_CNT_BITS'(MIN_CLKS_PER_BIT);
    localparam logic [NUM_BIT_BITS-1:0] ONE_BIT = NUM_BIT_BITS'(1);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [NUM_CNT_BITS-1:0] r_cpb;
    logic [NUM_BIT_BITS-1:0] r_bpf;
    logic [NUM_BIT_BITS-1:0] r_bit_count;
    logic                    r_busy;
    logic                    r_frame_done;
    logic                    r_err;

    logic                    w_strobe;
    logic                    w_in_frame;
    logic                    w_abort;
    logic                    w_accept;
    logic                    w_reject;
    logic                    w_last;
    logic                    w_clear;
    logic [NUM_CNT_BITS-1:0] w_c_src;
    logic [NUM_CNT_BITS-1:0] w_c_eff;
    logic [NUM_CNT_BITS-1:0] w_rollover;

    assign w_in_frame = (r_state == HALF) || (r_state == RUN);
    assign w_abort    = abort && (r_state != IDLE);
    assign w_accept   = start && !abort && (bits_per_frame != '0)
                        && ((r_state == IDLE) || (r_state == DONE));
    assign w_reject   = start && !abort && (w_in_frame || (bits_per_frame == '0));
    assign w_last     = (r_bit_count == (r_bpf - ONE_BIT));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next_state = HALF;
            end
            HALF: begin
                if (abort)         w_next_state = IDLE;
                else if (w_strobe) w_next_state = w_last ? DONE : RUN;
            end
            RUN: begin
                if (abort)                   w_next_state = IDLE;
                else if (w_strobe && w_last) w_next_state = DONE;
            end
            DONE: begin
                if (w_accept) w_next_state = HALF;
                else          w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Period comes from the live input on the accepting edge so the first strobe is not a cycle late.
    always_comb begin
        w_c_src    = w_accept ? clks_per_bit : r_cpb;
        w_c_eff    = (w_c_src < MIN_C) ? MIN_C : w_c_src;
        w_rollover = '0;
        case (w_next_state)
            HALF:    w_rollover = w_c_eff >> 1;
            RUN:     w_rollover = w_c_eff;
            default: w_rollover = '0;
        endcase
    end

    assign w_clear = w_accept || w_abort || (w_next_state != r_state);

    flex_counter #(
        .NUM_CNT_BITS (NUM_CNT_BITS)
    ) u_bit_period (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (w_clear),
        .count_enable  (w_in_frame),
        .rollover_val  (w_rollover),
        .rollover_flag (w_strobe)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= IDLE;
            r_cpb        <= '0;
            r_bpf        <= '0;
            r_bit_count  <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_cpb <= clks_per_bit;
                r_bpf <= bits_per_frame;
            end
            if (w_accept || w_abort)
                r_bit_count <= '0;
            else if (w_strobe && w_in_frame)
                r_bit_count <= r_bit_count + ONE_BIT;
            r_busy       <= (w_next_state == HALF) || (w_next_state == RUN);
            r_frame_done <= (w_next_state == DONE);
            r_err        <= w_reject;
        end
    end

    assign busy          = r_busy;
    assign sample_strobe = w_strobe;
    assign bit_count     = r_bit_count;
    assign frame_done    = r_frame_done;
    assign err           = r_err;

endmodule

// File: tb/tb_bit_timer_ctrl.sv
// Directed bench for bit_timer_ctrl with hand-computed strobe schedules.
module tb_bit_timer_ctrl;

    localparam int CW = 8;
    localparam int BW = 4;

    logic          clk            = 1'b0;
    logic          n_rst          = 1'b0;
    logic          start          = 1'b0;
    logic          abort          = 1'b0;
    logic [CW-1:0] clks_per_bit   = '0;
    logic [BW-1:0] bits_per_frame = '0;
    logic          busy;
    logic          sample_strobe;
    logic [BW-1:0] bit_count;
    logic          frame_done;
    logic          err;

    int n_cmp = 0;
    int n_mis = 0;

    bit_timer_ctrl #(
        .NUM_CNT_BITS (CW),
        .NUM_BIT_BITS (BW)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .start          (start),
        .abort          (abort),
        .clks_per_bit   (clks_per_bit),
        .bits_per_frame (bits_per_frame),
        .busy           (busy),
        .sample_strobe  (sample_strobe),
        .bit_count      (bit_count),
        .frame_done     (frame_done),
        .err            (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int k, input bit eb, input bit es, input bit ed, input bit ee);
        chk({tag, ".busy"},   k, {31'b0, busy},          {31'b0, eb});
        chk({tag, ".strobe"}, k, {31'b0, sample_strobe}, {31'b0, es});
        chk({tag, ".done"},   k, {31'b0, frame_done},    {31'b0, ed});
        chk({tag, ".err"},    k, {31'b0, err},           {31'b0, ee});
    endtask

    initial begin
        // reset state
        cyc();
        cyc();
        chk_out("rst", 0, 0, 0, 0, 0);
        chk("rst.cnt", 0, {28'b0, bit_count}, 0);
        n_rst = 1'b1;
        cyc();
        chk_out("idle", 0, 0, 0, 0, 0);

        // A: C=8 N=4, config changed mid-frame must not matter
        clks_per_bit = 8; bits_per_frame = 4; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            chk_out("A", k, (k >= 1 && k <= 28), (k == 4 || k == 12 || k == 20 || k == 28), (k == 29), 0);
            if (k == 5) chk("A.cnt", k, {28'b0, bit_count}, 1);
            if (k == 29 || k == 30) chk("A.cnt", k, {28'b0, bit_count}, 4);
            if (k == 2) begin clks_per_bit = 3; bits_per_frame = 7; end
            cyc();
        end

        // B: C=1 clamps to 2, N=2
        clks_per_bit = 1; bits_per_frame = 2; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chk_out("B", k, (k <= 3), (k == 1 || k == 3), (k == 4), 0);
            if (k == 2) chk("B.cnt", k, {28'b0, bit_count}, 1);
            if (k == 4) chk("B.cnt", k, {28'b0, bit_count}, 2);
            cyc();
        end

        // C: abort at t0+10
        clks_per_bit = 8; bits_per_frame = 4; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            chk_out("C", k, (k <= 10), (k == 4), 0, 0);
            if (k == 10) chk("C.cnt", k, {28'b0, bit_count}, 1);
            if (k == 11) chk("C.cnt", k, {28'b0, bit_count}, 0);
            if (k == 10) abort = 1'b1;
            if (k == 11) abort = 1'b0;
            cyc();
        end

        // D: start mid-frame rejected, start in DONE starts C=4 N=2 frame
        clks_per_bit = 8; bits_per_frame = 4; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 37; k++) begin
            chk_out("D", k,
                    (k >= 1 && k <= 28) || (k >= 30 && k <= 35),
                    (k == 4 || k == 12 || k == 20 || k == 28 || k == 31 || k == 35),
                    (k == 29 || k == 36),
                    (k == 7));
            if (k == 29) chk("D.cnt", k, {28'b0, bit_count}, 4);
            if (k == 30) chk("D.cnt", k, {28'b0, bit_count}, 0);
            if (k == 36) chk("D.cnt", k, {28'b0, bit_count}, 2);
            if (k == 6) start = 1'b1;
            if (k == 7) start = 1'b0;
            if (k == 29) begin clks_per_bit = 4; bits_per_frame = 2; start = 1'b1; end
            if (k == 30) start = 1'b0;
            cyc();
        end

        // E: N=0 rejected
        bits_per_frame = 0; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            chk_out("E", k, 0, 0, 0, (k == 1));
            cyc();
        end

        // F: reset mid-frame, then a clean C=2 N=3 frame
        clks_per_bit = 8; bits_per_frame = 4; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chk_out("F", k, 1, (k == 4), 0, 0);
            if (k < 5) cyc();
        end
        n_rst = 1'b0;
        #2;
        chk_out("F.rst", 5, 0, 0, 0, 0);
        chk("F.rst.cnt", 5, {28'b0, bit_count}, 0);
        cyc();
        cyc();
        n_rst = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk_out("F.post", k, 0, 0, 0, 0);
        end
        clks_per_bit = 2; bits_per_frame = 3; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            chk_out("G", k, (k <= 5), (k == 1 || k == 3 || k == 5), (k == 6), 0);
            if (k == 6) chk("G.cnt", k, {28'b0, bit_count}, 3);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/bit_timer_ctrl.md
BIT_TIMER_CTRL -- requirements
Module: bit_timer_ctrl

Interface
REQ-001 Param NUM_CNT_BITS, default 8, width of the clocks-per-bit configuration and internal cycle counter.
REQ-002 Param NUM_BIT_BITS, default 4, width of the bits-per-frame configuration and bit counter.
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 n_rst  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to begin timing a frame.
REQ-006 abort  in  1  terminate the current frame immediately.
REQ-007 clks_per_bit  in  NUM_CNT_BITS  clock cycles per bit period (C).
REQ-008 bits_per_frame  in  NUM_BIT_BITS  sample points per frame (N).
REQ-009 busy  out  1  frame in progress.
REQ-010 sample_strobe  out  1  one-cycle pulse at each bit-center sample point.
REQ-011 bit_count  out  NUM_BIT_BITS  strobes issued so far in the current frame.
REQ-012 frame_done  out  1  one-cycle pulse after the final strobe of a frame.
REQ-013 err  out  1  one-cycle pulse: start rejected (busy or N==0).

Function
REQ-014 The FSM SHALL have states IDLE, HALF, RUN and DONE.
REQ-015 IDLE, start=1, N!=0: latch C and N, go to HALF; busy=1 from the next cycle.
REQ-016 Effective C SHALL be max(C,2); half period H SHALL be floor(effective C / 2).
REQ-017 With start sampled at cycle t0, sample_strobe SHALL fire at t0+H, then at t0+H+k*C for k=1..N-1.
REQ-018 HALF→RUN on the first strobe; RUN→DONE on the N-th strobe.
REQ-019 DONE SHALL last one cycle with frame_done=1 and busy=0, then return to IDLE.
REQ-020 bit_count SHALL increment in the cycle after each strobe, clear to 0 on entry to HALF, and hold its final value N until the next start.
REQ-021 start while busy=1 SHALL be ignored with err=1; the current frame continues unaffected.
REQ-022 start in IDLE with N==0 SHALL be ignored with err=1; the FSM stays in IDLE.
REQ-023 start in the DONE cycle SHALL be accepted as in IDLE, so back-to-back frames are possible.
REQ-024 abort in any non-IDLE state SHALL force IDLE on the next edge, clear busy, suppress frame_done and any pending strobe, and reset the counters; abort has priority over start.
REQ-025 Changes to C or N while busy SHALL have no effect until the next accepted start.
REQ-026 All outputs SHALL be registered; sample_strobe, frame_done and err SHALL each be at most one cycle wide.

Reset
REQ-027 On n_rst=0: state=IDLE, busy=0, sample_strobe=0, bit_count=0, frame_done=0, err=0, latched C/N=0, independent of clk.
REQ-028 Reset mid-frame SHALL abandon the frame without emitting frame_done after release.

Structure
REQ-029 A shared package bit_timer_pkg SHALL hold the state enum type (IDLE, HALF, RUN, DONE) and the minimum-C constant (2).
REQ-030 The bit-period counter SHALL be one instance of the team's flex_counter (NUM_CNT_BITS wide); rollover_val=H in HALF and C in RUN, clear asserted on start acceptance, state change and abort, and rollover_flag used as the strobe source.
REQ-031 The bit counter, FSM and output registers SHALL be local logic within bit_timer_ctrl.

Verification
REQ-032 C=8, N=4, start at t0 -> strobes at t0+4, +12, +20, +28; frame_done at t0+29; bit_count=4; busy high t0+1..t0+28.
REQ-033 C=1 (clamped to 2), N=2, start at t0 -> strobes at t0+1 and t0+3; frame_done at t0+4.
REQ-034 C=8, N=4, abort at t0+10 -> busy=0 at t0+11; no further strobes; no frame_done.
REQ-035 start at t0+6 mid-frame -> err pulse at t0+7; strobe timing unchanged; start in the DONE cycle -> new frame begins, err=0.
REQ-036 N=0 start -> err=1 for one cycle, busy stays 0; n_rst low mid-frame -> all outputs 0 immediately, and the first post-reset start times correctly.
